// File: rtl/bram_stream_reader_if.sv
// Handshake and bus bundle between a BRAM stream reader and its RAM port, controller and sink.
// The slave modport is the reader; the master modport is the environment around it.
interface bram_stream_reader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic [ADDR_WIDTH:0]   length;
   logic                  abort;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  mem_wren;
   logic [DATA_WIDTH-1:0] mem_q;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport slave (
      input  start, start_addr, length, abort, mem_q, out_ready,
      output busy, done, mem_address, mem_wren, out_data, out_valid
   );

   modport master (
      output start, start_addr, length, abort, mem_q, out_ready,
      input  busy, done, mem_address, mem_wren, out_data, out_valid
   );
endinterface

// File: rtl/bram_stream_reader.sv
// Sequential BRAM read initiator: fetches length words from start_addr and streams them out.
// One read may be in flight; returning data lands in a 2-entry FIFO that drives the stream.
module bram_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10
) (
   input logic                 clock,
   input logic                 reset_n,
   bram_stream_reader_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                r_state;
   logic                  r_busy;
   logic                  r_done;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH:0]   r_issue_left;
   logic [ADDR_WIDTH:0]   r_out_left;
   logic                  r_inflight;
   logic [DATA_WIDTH-1:0] r_buf [2];
   logic                  r_rd_ptr;
   logic                  r_wr_ptr;
   logic [1:0]            r_count;

   logic       w_pop;
   logic       w_push;
   logic [2:0] w_level;
   logic       w_issue;
   logic       w_last;

   // Occupancy counts the in-flight read so a stalled sink can never overflow the FIFO.
   assign w_pop   = (r_count != 2'd0) && bus.out_ready;
   assign w_push  = r_inflight;
   assign w_level = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue = (r_state == S_RUN) && (r_issue_left != '0) && (w_level < 3'd2);
   assign w_last  = w_pop && (r_out_left == (ADDR_WIDTH+1)'(1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_addr       <= '0;
         r_issue_left <= '0;
         r_out_left   <= '0;
         r_inflight   <= 1'b0;
         r_buf[0]     <= '0;
         r_buf[1]     <= '0;
         r_rd_ptr     <= 1'b0;
         r_wr_ptr     <= 1'b0;
         r_count      <= 2'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_busy <= 1'b1;
                  if (bus.length == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state      <= S_RUN;
                     r_addr       <= bus.start_addr;
                     r_issue_left <= bus.length;
                     r_out_left   <= bus.length;
                  end
               end
            end
            S_RUN: begin
               if (bus.abort) begin
                  r_state    <= S_IDLE;
                  r_busy     <= 1'b0;
                  r_inflight <= 1'b0;
                  r_rd_ptr   <= 1'b0;
                  r_wr_ptr   <= 1'b0;
                  r_count    <= 2'd0;
               end else begin
                  r_inflight <= w_issue;
                  if (w_issue) begin
                     r_addr       <= r_addr + 1'b1;
                     r_issue_left <= r_issue_left - 1'b1;
                  end
                  if (w_push) begin
                     r_buf[r_wr_ptr] <= bus.mem_q;
                     r_wr_ptr        <= ~r_wr_ptr;
                  end
                  if (w_pop) begin
                     r_rd_ptr   <= ~r_rd_ptr;
                     r_out_left <= r_out_left - 1'b1;
                  end
                  r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
                  if (w_last) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state    <= S_IDLE;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
               r_inflight <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   always @(posedge clock) begin
      if (reset_n && r_state == S_RUN && !bus.abort)
         assert (!(w_push && !w_pop && r_count == 2'd2));
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.mem_address = r_addr;
   assign bus.mem_wren    = 1'b0;
   assign bus.out_data    = r_buf[r_rd_ptr];
   assign bus.out_valid   = (r_count != 2'd0);
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed and randomized bench for bram_stream_reader; expected streams come from a
// queue of mem[(start+i) mod 1024], and timing from the stated latency/busy rules.
module tb_bram_stream_reader;
   logic clock = 1'b0;
   logic reset_n;

   bram_stream_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) bus ();

   bram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   logic [7:0] mem [0:1023];
   always @(posedge clock) bus.mem_q <= mem[bus.mem_address];

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_q [$];
   logic [7:0] got [$];
   logic [9:0] addr_trace [$];
   int busy_cnt, done_cnt, first_valid, first_xfer, last_xfer, done_cyc, stab_err;
   bit timed_out;
   logic [9:0] stall_addr;
   logic [7:0] stall_data;
   logic [9:0] saved_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},      32'(bus.busy),        0);
      chk({tag, "_done"},      32'(bus.done),        0);
      chk({tag, "_out_valid"}, 32'(bus.out_valid),   0);
      chk({tag, "_out_data"},  32'(bus.out_data),    0);
      chk({tag, "_mem_addr"},  32'(bus.mem_address), 0);
      chk({tag, "_mem_wren"},  32'(bus.mem_wren),    0);
   endtask

   // Compares the first n received words against the model queue.
   task automatic chk_words(input string tag, input int n);
      chk({tag, "_count"}, 32'(got.size()), 32'(n));
      for (int i = 0; i < n && i < got.size(); i++)
         chk({tag, "_word"}, 32'(got[i]), 32'(exp_q[i]));
   endtask

   // mode 0: ready always 1; mode 1: ready random 50%; mode 2: ready 0 for `stall` cycles then 1.
   task automatic run_xfer(input logic [9:0] a, input logic [10:0] n, input int mode,
                           input int stall, input int abort_at, input bit use_rst, input int budget);
      logic       prev_v, prev_r;
      logic [7:0] prev_d;
      exp_q.delete(); got.delete(); addr_trace.delete();
      for (int i = 0; i < int'(n); i++) exp_q.push_back(mem[10'(int'(a) + i)]);
      busy_cnt = 0; done_cnt = 0; first_valid = -1; first_xfer = -1; last_xfer = -1;
      done_cyc = -1; stab_err = 0; timed_out = 1'b1;
      prev_v = 1'b0; prev_r = 1'b0; prev_d = 8'h00;
      @(negedge clock);
      bus.start = 1'b1; bus.start_addr = a; bus.length = n;
      @(negedge clock);
      bus.start = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (abort_at >= 0 && got.size() == abort_at) begin
            timed_out = 1'b0;
            if (use_rst) begin
               reset_n = 1'b0;
               #1;
               chk_reset_outputs("midreset");
               #1 reset_n = 1'b1;
            end else begin
               bus.abort = 1'b1; bus.out_ready = 1'b1;
               @(negedge clock);
               bus.abort = 1'b0;
               chk("abort_out_valid", 32'(bus.out_valid), 0);
               chk("abort_busy",      32'(bus.busy),      0);
               chk("abort_done",      32'(bus.done),      0);
               @(negedge clock);
               chk("abort_no_done_later", 32'(bus.done), 0);
            end
            break;
         end
         if (bus.busy) busy_cnt++;
         if (bus.done) begin done_cnt++; done_cyc = c; end
         if (bus.out_valid && first_valid < 0) first_valid = c;
         if (prev_v && !prev_r && (!bus.out_valid || bus.out_data !== prev_d)) stab_err++;
         if (addr_trace.size() == 0 || addr_trace[$] !== bus.mem_address)
            addr_trace.push_back(bus.mem_address);
         if (mode == 2 && c == stall) begin
            stall_addr = bus.mem_address; stall_data = bus.out_data;
         end
         case (mode)
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            2:       bus.out_ready = (c >= stall);
            default: bus.out_ready = 1'b1;
         endcase
         if (bus.out_valid && bus.out_ready) begin
            got.push_back(bus.out_data);
            if (first_xfer < 0) first_xfer = c;
            last_xfer = c;
         end
         prev_v = bus.out_valid; prev_r = bus.out_ready; prev_d = bus.out_data;
         if (!bus.busy) begin timed_out = 1'b0; break; end
         @(negedge clock);
      end
      chk("no_timeout", 32'(timed_out), 0);
   endtask

   initial begin
      reset_n = 1'b0;
      bus.start = 1'b0; bus.start_addr = '0; bus.length = '0;
      bus.abort = 1'b0; bus.out_ready = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
      repeat (2) @(negedge clock);
      chk_reset_outputs("reset");
      reset_n = 1'b1;

      // Basic 4-word stream with sink always ready
      run_xfer(10'h010, 11'd4, 0, 0, -1, 1'b0, 100);
      chk_words("basic", 4);
      chk("basic_first_valid", 32'(first_valid), 2);
      chk("basic_first_xfer", 32'(first_xfer), 2);
      chk("basic_last_xfer", 32'(last_xfer), 5);
      chk("basic_done_cnt", 32'(done_cnt), 1);
      chk("basic_done_cyc", 32'(done_cyc), 32'(last_xfer + 1));
      chk("basic_busy_cycles", 32'(busy_cnt), 7);

      // Address wrap
      run_xfer(10'h3FE, 11'd4, 0, 0, -1, 1'b0, 100);
      chk_words("wrap", 4);
      chk("wrap_trace_len", 32'(addr_trace.size() >= 4), 1);
      for (int i = 0; i < 4 && i < addr_trace.size(); i++)
         chk("wrap_addr", 32'(addr_trace[i]), 32'(10'(10'h3FE + i)));
      chk("wrap_busy_cycles", 32'(busy_cnt), 7);

      // Backpressure: sink stalls 10 cycles
      run_xfer(10'h010, 11'd6, 2, 10, -1, 1'b0, 200);
      chk("stall_addr", 32'(stall_addr), 32'h012);
      chk("stall_data", 32'(stall_data), 32'h10);
      chk("stall_stable", 32'(stab_err), 0);
      chk_words("stall", 6);
      chk("stall_done_cnt", 32'(done_cnt), 1);

      // Full memory sweep with random sink readiness
      run_xfer(10'h000, 11'd1024, 1, 0, -1, 1'b0, 6000);
      chk_words("sweep", 1024);
      chk("sweep_done_cnt", 32'(done_cnt), 1);
      chk("sweep_stable", 32'(stab_err), 0);

      // Zero length
      saved_addr = bus.mem_address;
      run_xfer(10'h155, 11'd0, 0, 0, -1, 1'b0, 20);
      chk("zero_done_cyc", 32'(done_cyc), 0);
      chk("zero_done_cnt", 32'(done_cnt), 1);
      chk("zero_no_valid", 32'(first_valid), 32'(-1));
      chk("zero_addr_steady", 32'(addr_trace.size()), 1);
      chk("zero_addr_value", 32'(bus.mem_address), 32'(saved_addr));
      chk("zero_busy_cycles", 32'(busy_cnt), 1);

      // Abort after 3 words, then a clean restart
      run_xfer(10'h040, 11'd8, 0, 0, 3, 1'b0, 100);
      chk_words("abort_prefix", 3);
      run_xfer(10'h020, 11'd2, 0, 0, -1, 1'b0, 100);
      chk_words("after_abort", 2);
      chk("after_abort_done", 32'(done_cnt), 1);

      // Same with reset in place of abort
      run_xfer(10'h040, 11'd8, 0, 0, 3, 1'b1, 100);
      chk_words("reset_prefix", 3);
      run_xfer(10'h020, 11'd2, 0, 0, -1, 1'b0, 100);
      chk_words("after_reset", 2);
      chk("after_reset_done", 32'(done_cnt), 1);

      // Random contents, addresses, lengths and sink behaviour
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      for (int t = 0; t < 4; t++) begin
         logic [9:0]  ra;
         logic [10:0] rn;
         ra = 10'($urandom);
         rn = 11'($urandom_range(1, 64));
         run_xfer(ra, rn, 1, 0, -1, 1'b0, 1000);
         chk_words("rand", int'(rn));
         chk("rand_done_cnt", 32'(done_cnt), 1);
         chk("rand_stable", 32'(stab_err), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
